// File: rtl/bp_lce_req_arbiter.sv
// Round-robin merge of per-LCE request channels into one registered 2-entry
// output buffer; each entry carries its source index alongside the message.
module bp_lce_req_arbiter #(
    parameter int num_lce_p       = 2,
    parameter int lce_req_width_p = 128,
    localparam int src_width_lp   = (num_lce_p > 1) ? $clog2(num_lce_p) : 1
) (
    input  logic                                       clk_i,
    input  logic                                       reset_i,
    input  logic [num_lce_p-1:0][lce_req_width_p-1:0]  lce_req_i,
    input  logic [num_lce_p-1:0]                       lce_req_v_i,
    output logic [num_lce_p-1:0]                       lce_req_yumi_o,
    output logic [lce_req_width_p-1:0]                 lce_req_o,
    output logic [src_width_lp-1:0]                    lce_req_src_o,
    output logic                                       lce_req_v_o,
    input  logic                                       lce_req_ready_i
);

    localparam logic [src_width_lp-1:0] LastIdx = src_width_lp'(num_lce_p - 1);
    localparam logic [src_width_lp-1:0] OneIdx  = src_width_lp'(1);

    logic [1:0]                 count_q, count_d;
    logic                       head_q, head_d;
    logic [src_width_lp-1:0]    last_q, last_d;
    logic [lce_req_width_p-1:0] msg_q [2];
    logic [src_width_lp-1:0]    src_q [2];

    logic                       space, found, enq, deq, wr_ptr;
    logic [src_width_lp-1:0]    cand, win;

    // Search starts just after the last winner and wraps explicitly, so
    // non-power-of-two sizes never visit an index >= num_lce_p.
    always_comb begin
        cand  = last_q;
        win   = last_q;
        found = 1'b0;
        for (int i = 0; i < num_lce_p; i++) begin
            cand = (cand == LastIdx) ? '0 : cand + OneIdx;
            if (!found && lce_req_v_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Space comes from registered count only, so ready_i never reaches yumi.
    assign space       = (count_q != 2'd2);
    assign lce_req_v_o = (count_q != 2'd0);
    assign deq         = lce_req_v_o & lce_req_ready_i;
    assign enq         = found & space & reset_i;
    assign wr_ptr      = head_q ^ count_q[0];

    always_comb begin
        lce_req_yumi_o = '0;
        if (enq) begin
            lce_req_yumi_o[win] = 1'b1;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({enq, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        head_d = head_q ^ deq;
        last_d = enq ? win : last_q;
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            last_q  <= LastIdx;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            last_q  <= last_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (enq) begin
            msg_q[wr_ptr] <= lce_req_i[win];
            src_q[wr_ptr] <= win;
        end
    end

    assign lce_req_o     = lce_req_v_o ? msg_q[head_q] : '0;
    assign lce_req_src_o = lce_req_v_o ? src_q[head_q] : '0;

endmodule

// File: doc/bp_lce_req_arbiter.md
# bp_lce_req_arbiter

Round-robin arbiter merging the LCE request channels of a core's cache engines (I$ LCE at index 0, D$ LCE at index 1, more when configured) onto one shared LCE-to-CCE request network port. Each accepted message lands in a registered 2-entry output buffer, tagged with its source index. The output is therefore fully registered, and the network's ready never combinationally reaches any LCE. Sits between the per-core LCEs and the coherence network when a tile exposes a single request link.

## Interface
- num_lce_p, default 2: number of requesting LCEs, ≥2, need not be a power of two.
- lce_req_width_p, default 128: width of one LCE request message.
- src_width_lp (local) = `BSG_SAFE_CLOG2(num_lce_p)`.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- reset_i  in  1  reset; asynchronous assert, active-low (0 = in reset); deassertion assumed synchronized upstream.
- lce_req_i  in  [num_lce_p][lce_req_width_p]  per-LCE request message.
- lce_req_v_i  in  num_lce_p  per-LCE valid; must not depend on lce_req_yumi_o.
- lce_req_yumi_o  out  num_lce_p  one-hot (or zero) consume strobe; message k is taken this cycle.
- lce_req_o  out  lce_req_width_p  buffer head message.
- lce_req_src_o  out  src_width_lp  source index of head message.
- lce_req_v_o  out  1  head valid; depends only on registered state.
- lce_req_ready_i  in  1  network ready; transfer on v_o & ready_i.

## Operation
- Buffer: 2-entry FIFO holding {message, src}, with count_r in {0,1,2}.
  - Enqueue when any yumi bit is set.
  - Dequeue on lce_req_v_o & lce_req_ready_i.
- space = (count_r != 2). Full is decided on registered count only. A same-cycle dequeue does not open space (no pass-through), so lce_req_ready_i never reaches yumi.
- Arbitration, combinational:
  - Search indices last_r+1, last_r+2, … modulo num_lce_p, wrapping explicitly from num_lce_p-1 to 0.
  - The first index with lce_req_v_i set wins.
  - lce_req_yumi_o[win] = space; all other bits 0.
  - No valid inputs or !space: yumi all 0.
- last_r updates to the winner only on an actual grant. Unchanged otherwise.
- Arbitration is per message: no locking across messages.
- With all inputs continuously valid, grants rotate 0,1,…,N-1,0,…
- Starvation bound: a valid requester is granted within num_lce_p grants.
- Count update:
  - enq only: +1.
  - deq only: -1.
  - both: unchanged; the head advances and the new entry is written behind it.
  - count 0: enq writes the head, visible next cycle.

## Timing
- Reset (reset_i=0, async):
  - count_r=0, so lce_req_v_o=0.
  - lce_req_yumi_o=0.
  - last_r=num_lce_p-1, so index 0 has first priority.
  - lce_req_src_o=0, lce_req_o=0.
  - Storage contents are don't-care but are driven 0 on the outputs while empty.
- Latency: a message granted in cycle t is at the head with lce_req_v_o=1 in cycle t+1 when the buffer was empty.
- Throughput: 1 message/cycle sustained while lce_req_ready_i=1. Count stays ≤1 in that case.
- Backpressure:
  - ready_i=0 with two grants: count reaches 2 and yumi drops to 0 the next cycle.
  - After a dequeue from full, yumi may assert again one cycle later.
- Head stability: while lce_req_v_o=1 and ready_i=0, lce_req_o and lce_req_src_o hold stable.
- Reset mid-operation discards buffered messages and restores priority to index 0. Messages whose yumi fired in the reset cycle are lost; upstream is reset together.

## Test plan
- Reset/idle:
  - Hold reset_i=0 with inputs valid, then release.
  - During reset, yumi=0 and v_o=0.
  - First cycle after release: yumi=2'b01.
  - Next cycle: v_o=1, src_o=0.
- Round-robin:
  - Both inputs always valid, ready_i=1.
  - Yumi alternates 01,10,01,…
  - src_o sequence 0,1,0,1 with 1-cycle latency; 1 message/cycle.
- Full buffer:
  - ready_i=0, both valid.
  - Two grants (src 0, then 1), then yumi=0.
  - count=2 holds indefinitely with head stable.
  - Raise ready_i: the src 0 message leaves; yumi resumes one cycle later with src 0.
- Simultaneous enq/deq at count 1:
  - ready_i=1, single requester 1 always valid.
  - count stays 1.
  - Messages A,B,C exit in order, src_o=1 throughout.
- Wrap-around with num_lce_p=3:
  - last_r=2; only index 1 valid → grant 1.
  - Next cycle all valid → grant 2, then 0.
  - Verifies modulo order on a non-power-of-two size.
- Async reset mid-stream:
  - Assert reset_i=0 between clock edges with count=2.
  - v_o drops to 0 immediately, without waiting for an edge.
  - After release, priority restarts at index 0.
